rx_iq_scheduler: RTL and testbench

Collects 24-bit I/Q samples from the RX1 and RX2 DDC chains and pairs them into frames. Frames are buffered in a small FIFO and handed to `stm32_interface` one per read request. It sits between the DDC outputs and the STM32 parallel-bus interface. It replaces direct sampling of live DDC outputs with a lossless queue and reports overrun and underrun through sticky flags.

---
 rtl/ddc_pkg.sv | 30 +++
 rtl/iq_frame_fifo.sv | 89 ++++++++
 rtl/rx_iq_scheduler.sv | 136 +++++++++++++
 tb/tb_rx_iq_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_pkg.sv
// Shared definitions for the DDC receive path and the STM32 parallel-bus interface.
package ddc_pkg;

    localparam int DATA_W = 24;

    // One paired frame, MSB first: RX1 I, RX1 Q, RX2 I, RX2 Q.
    typedef struct packed {
        logic signed [DATA_W-1:0] rx1_i;
        logic signed [DATA_W-1:0] rx1_q;
        logic signed [DATA_W-1:0] rx2_i;
        logic signed [DATA_W-1:0] rx2_q;
    } iq_frame_t;

    localparam int FRAME_W = $bits(iq_frame_t);

    typedef enum logic [3:0] {
        CMD_NOP        = 4'd0,
        CMD_SET_PARAMS = 4'd1,
        CMD_GET_PARAMS = 4'd2,
        CMD_START      = 4'd3,
        CMD_STOP       = 4'd4,
        CMD_RESET      = 4'd5,
        CMD_IQ_SYNC    = 4'd6,
        CMD_IQ_READ    = 4'd7,
        CMD_STATUS     = 4'd8,
        CMD_OVF_CLR    = 4'd9,
        CMD_VERSION    = 4'd10
    } stm32_cmd_e;

endpackage

// File: rtl/iq_frame_fifo.sv
// Synchronous frame FIFO with flush, registered pop output and an explicit level count.
module iq_frame_fifo #(
    parameter int WIDTH = ddc_pkg::FRAME_W,
    parameter int DEPTH = 8
) (
    input  logic                       clk_in,
    input  logic                       reset_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       rd_valid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             push_ok, pop_ok;

    assign full_o     = (level_q == LW'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

    // A pop frees the head slot this edge, so a push into a full FIFO is accepted alongside it.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        pop_ok     = pop_i && !empty_o && !flush_i;
        push_ok    = push_i && !flush_i && (!full_o || pop_ok);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop_ok;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                rd_data_d = mem_q[rd_ptr_q];
            end
            level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        // NOTE: sequential state is only ever assigned with <= so every register samples
        // the pre-edge values of its neighbours regardless of statement order.
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        // NOTE: the storage array is reset too, so the block has no undefined state after
        // reset; flush only moves the pointers and leaves stale words unreadable.
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/rx_iq_scheduler.sv
// Pairs RX1/RX2 DDC samples into frames, queues them losslessly and serves one frame per
// read request, with sticky overrun/underrun flags.
module rx_iq_scheduler #(
    parameter int DATA_W = ddc_pkg::DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                       clk_in,
    input  logic                       reset_n,
    input  logic                       rx1_en,
    input  logic                       rx2_en,
    input  logic signed [DATA_W-1:0]   rx1_i,
    input  logic signed [DATA_W-1:0]   rx1_q,
    input  logic signed [DATA_W-1:0]   rx2_i,
    input  logic signed [DATA_W-1:0]   rx2_q,
    input  logic                       rx1_valid,
    input  logic                       rx2_valid,
    input  logic                       rd_req,
    input  logic                       ovf_clr,
    output logic signed [DATA_W-1:0]   out_rx1_i,
    output logic signed [DATA_W-1:0]   out_rx1_q,
    output logic signed [DATA_W-1:0]   out_rx2_i,
    output logic signed [DATA_W-1:0]   out_rx2_q,
    output logic                       out_valid,
    output logic                       iq_overrun,
    output logic                       iq_underrun,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int FRAME_W = 4 * DATA_W;

    logic                rx1_en_q, rx2_en_q;
    logic                s1_full_q, s1_full_d, s2_full_q, s2_full_d;
    logic [DATA_W-1:0]   s1_i_q, s1_i_d, s1_q_q, s1_q_d;
    logic [DATA_W-1:0]   s2_i_q, s2_i_d, s2_q_q, s2_q_d;
    logic                push_q, push_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                ovr_q, ovr_d, udr_q, udr_d;

    logic                mode_flush, cap1, cap2, full1, full2, frame_complete;
    logic                fifo_full, fifo_empty, pop_hit;
    logic [FRAME_W-1:0]  rd_data;

    // Any rx2_en change or RX1 shutdown invalidates frame pairing, so queued data is dropped.
    always_comb begin
        mode_flush     = (rx2_en != rx2_en_q) || (rx1_en_q && !rx1_en);
        cap1           = rx1_en && rx1_valid;
        cap2           = rx1_en && rx2_en && rx2_valid;
        s1_i_d         = cap1 ? rx1_i : s1_i_q;
        s1_q_d         = cap1 ? rx1_q : s1_q_q;
        s2_i_d         = cap2 ? rx2_i : s2_i_q;
        s2_q_d         = cap2 ? rx2_q : s2_q_q;
        full1          = s1_full_q || cap1;
        full2          = s2_full_q || cap2;
        frame_complete = rx1_en && full1 && (!rx2_en || full2);
        s1_full_d      = full1;
        s2_full_d      = full2;
        push_d         = 1'b0;
        frame_d        = frame_q;
        if (mode_flush) begin
            s1_full_d = 1'b0;
            s2_full_d = 1'b0;
            s1_i_d    = '0;
            s1_q_d    = '0;
            s2_i_d    = '0;
            s2_q_d    = '0;
        end else if (frame_complete) begin
            s1_full_d = 1'b0;
            s2_full_d = 1'b0;
            push_d    = 1'b1;
            frame_d   = rx2_en ? {s1_i_d, s1_q_d, s2_i_d, s2_q_d}
                               : {s1_i_d, s1_q_d, {(2 * DATA_W){1'b0}}};
        end
    end

    // A set event in the same cycle as ovf_clr keeps the flag raised.
    always_comb begin
        pop_hit = rd_req && !fifo_empty;
        ovr_d   = (!mode_flush && push_q && fifo_full && !pop_hit) || (ovr_q && !ovf_clr);
        udr_d   = (!mode_flush && rd_req && fifo_empty) || (udr_q && !ovf_clr);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rx1_en_q  <= 1'b0;
            rx2_en_q  <= 1'b0;
            s1_full_q <= 1'b0;
            s2_full_q <= 1'b0;
            s1_i_q    <= '0;
            s1_q_q    <= '0;
            s2_i_q    <= '0;
            s2_q_q    <= '0;
            push_q    <= 1'b0;
            frame_q   <= '0;
            ovr_q     <= 1'b0;
            udr_q     <= 1'b0;
        end else begin
            rx1_en_q  <= rx1_en;
            rx2_en_q  <= rx2_en;
            s1_full_q <= s1_full_d;
            s2_full_q <= s2_full_d;
            s1_i_q    <= s1_i_d;
            s1_q_q    <= s1_q_d;
            s2_i_q    <= s2_i_d;
            s2_q_q    <= s2_q_d;
            push_q    <= push_d;
            frame_q   <= frame_d;
            ovr_q     <= ovr_d;
            udr_q     <= udr_d;
        end
    end

    iq_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .flush_i     (mode_flush),
        .push_i      (push_q),
        .push_data_i (frame_q),
        .pop_i       (rd_req),
        .rd_data_o   (rd_data),
        .rd_valid_o  (out_valid),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    assign out_rx1_i   = rd_data[4*DATA_W-1 -: DATA_W];
    assign out_rx1_q   = rd_data[3*DATA_W-1 -: DATA_W];
    assign out_rx2_i   = rd_data[2*DATA_W-1 -: DATA_W];
    assign out_rx2_q   = rd_data[DATA_W-1 -: DATA_W];
    assign iq_overrun  = ovr_q;
    assign iq_underrun = udr_q;

endmodule

// File: tb/tb_rx_iq_scheduler.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a random
// run compared against a queue-based frame model.
module tb_rx_iq_scheduler;
    import ddc_pkg::*;

    localparam int DW    = DATA_W;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk_in = 1'b0;
    logic reset_n;
    logic rx1_en, rx2_en, rx1_valid, rx2_valid, rd_req, ovf_clr;
    logic signed [DW-1:0] rx1_i, rx1_q, rx2_i, rx2_q;
    logic signed [DW-1:0] out_rx1_i, out_rx1_q, out_rx2_i, out_rx2_q;
    logic out_valid, iq_overrun, iq_underrun;
    logic [LW-1:0] fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    rx_iq_scheduler #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .rx1_en      (rx1_en),
        .rx2_en      (rx2_en),
        .rx1_i       (rx1_i),
        .rx1_q       (rx1_q),
        .rx2_i       (rx2_i),
        .rx2_q       (rx2_q),
        .rx1_valid   (rx1_valid),
        .rx2_valid   (rx2_valid),
        .rd_req      (rd_req),
        .ovf_clr     (ovf_clr),
        .out_rx1_i   (out_rx1_i),
        .out_rx1_q   (out_rx1_q),
        .out_rx2_i   (out_rx2_i),
        .out_rx2_q   (out_rx2_q),
        .out_valid   (out_valid),
        .iq_overrun  (iq_overrun),
        .iq_underrun (iq_underrun),
        .fifo_level  (fifo_level)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames as queue entries, slots as "have a sample" bits.
    iq_frame_t mq[$];
    iq_frame_t m_pend_f, m_out;
    bit m_pend, m_h1, m_h2, m_p1, m_p2, m_ov, m_ovr, m_udr;
    logic [DW-1:0] m_s1i, m_s1q, m_s2i, m_s2q;

    function automatic void model_reset();
        mq.delete();
        m_pend_f = '0; m_out = '0;
        m_pend = 0; m_h1 = 0; m_h2 = 0; m_p1 = 0; m_p2 = 0;
        m_ov = 0; m_ovr = 0; m_udr = 0;
        m_s1i = '0; m_s1q = '0; m_s2i = '0; m_s2q = '0;
    endfunction

    function automatic void model_update();
        bit flush, pop_ok, ovr_set, udr_set;
        int sz;
        flush   = (rx2_en != m_p2) || (m_p1 && !rx1_en);
        sz      = mq.size();
        ovr_set = 0;
        udr_set = 0;
        m_ov    = 0;
        if (flush) begin
            mq.delete();
            m_pend = 0; m_h1 = 0; m_h2 = 0;
        end else begin
            pop_ok = rd_req && (sz > 0);
            if (rd_req && sz == 0) udr_set = 1;
            if (pop_ok) begin
                m_out = mq.pop_front();
                m_ov  = 1;
            end
            if (m_pend) begin
                if (sz < DEPTH || pop_ok) mq.push_back(m_pend_f);
                else ovr_set = 1;
            end
            m_pend = 0;
            if (rx1_en) begin
                if (rx1_valid) begin m_s1i = rx1_i; m_s1q = rx1_q; m_h1 = 1; end
                if (rx2_en && rx2_valid) begin m_s2i = rx2_i; m_s2q = rx2_q; m_h2 = 1; end
                if (m_h1 && (!rx2_en || m_h2)) begin
                    m_pend_f.rx1_i = m_s1i;
                    m_pend_f.rx1_q = m_s1q;
                    m_pend_f.rx2_i = rx2_en ? m_s2i : '0;
                    m_pend_f.rx2_q = rx2_en ? m_s2q : '0;
                    m_pend = 1; m_h1 = 0; m_h2 = 0;
                end
            end
        end
        m_ovr = ovr_set || (m_ovr && !ovf_clr);
        m_udr = udr_set || (m_udr && !ovf_clr);
        m_p1  = rx1_en;
        m_p2  = rx2_en;
    endfunction

    task automatic cyc(input bit v1, input logic [DW-1:0] i1, input logic [DW-1:0] q1,
                       input bit v2, input logic [DW-1:0] i2, input logic [DW-1:0] q2,
                       input bit rd, input bit clr);
        rx1_valid = v1; rx1_i = i1; rx1_q = q1;
        rx2_valid = v2; rx2_i = i2; rx2_q = q2;
        rd_req = rd; ovf_clr = clr;
        @(posedge clk_in);
        model_update();
        @(negedge clk_in);
        rx1_valid = 0; rx2_valid = 0; rd_req = 0; ovf_clr = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, '0, '0, 0, '0, '0, 0, 0);
    endtask

    task automatic strobe1(input logic [DW-1:0] i1, input logic [DW-1:0] q1);
        cyc(1, i1, q1, 0, '0, '0, 0, 0);
    endtask

    task automatic read1();
        cyc(0, '0, '0, 0, '0, '0, 1, 0);
    endtask

    function automatic logic [127:0] out_frame();
        return 128'({out_rx1_i, out_rx1_q, out_rx2_i, out_rx2_q});
    endfunction

    typedef struct {
        bit en1, en2, v1, rd, clr;
        logic [DW-1:0] i1;
        bit e_valid, e_udr;
        logic [DW-1:0] e_i1, e_q1;
        int e_lvl;
    } vec_t;

    vec_t vecs[11];
    int rd_pct;

    initial begin
        // en1 en2 v1 rd clr  i1   | valid udr  out_i1  out_q1      level
        vecs[0]  = '{1, 0, 0, 0, 0, 24'h0, 0, 0, 24'h0, 24'h0,      0};
        vecs[1]  = '{1, 0, 1, 0, 0, 24'h1, 0, 0, 24'h0, 24'h0,      0};
        vecs[2]  = '{1, 0, 1, 0, 0, 24'h2, 0, 0, 24'h0, 24'h0,      1};
        vecs[3]  = '{1, 0, 1, 0, 0, 24'h3, 0, 0, 24'h0, 24'h0,      2};
        vecs[4]  = '{1, 0, 0, 0, 0, 24'h0, 0, 0, 24'h0, 24'h0,      3};
        vecs[5]  = '{1, 0, 0, 1, 0, 24'h0, 1, 0, 24'h1, 24'h100000, 2};
        vecs[6]  = '{1, 0, 0, 1, 0, 24'h0, 1, 0, 24'h2, 24'h100000, 1};
        vecs[7]  = '{1, 0, 0, 1, 0, 24'h0, 1, 0, 24'h3, 24'h100000, 0};
        vecs[8]  = '{1, 0, 0, 0, 0, 24'h0, 0, 0, 24'h3, 24'h100000, 0};
        vecs[9]  = '{1, 0, 0, 1, 0, 24'h0, 0, 1, 24'h3, 24'h100000, 0};
        vecs[10] = '{1, 0, 0, 0, 1, 24'h0, 0, 0, 24'h3, 24'h100000, 0};

        reset_n = 0;
        rx1_en = 0; rx2_en = 0; rx1_valid = 0; rx2_valid = 0; rd_req = 0; ovf_clr = 0;
        rx1_i = '0; rx1_q = '0; rx2_i = '0; rx2_q = '0;
        model_reset();
        repeat (2) @(negedge clk_in);
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_level", 128'(fifo_level), 128'(0));
        check("rst_ovr", 128'(iq_overrun), 128'(0));
        check("rst_udr", 128'(iq_underrun), 128'(0));
        check("rst_frame", out_frame(), 128'(0));
        reset_n = 1;

        // Directed table: RX1-only frames, in-order readout, underrun and clear.
        for (int r = 0; r < 11; r++) begin
            rx1_en = vecs[r].en1;
            rx2_en = vecs[r].en2;
            cyc(vecs[r].v1, vecs[r].i1, 24'h100000, 0, '0, '0, vecs[r].rd, vecs[r].clr);
            check($sformatf("vec%0d_valid", r), 128'(out_valid), 128'(vecs[r].e_valid));
            check($sformatf("vec%0d_rx1_i", r), 128'(out_rx1_i), 128'(vecs[r].e_i1));
            check($sformatf("vec%0d_rx1_q", r), 128'(out_rx1_q), 128'(vecs[r].e_q1));
            check($sformatf("vec%0d_rx2", r), 128'({out_rx2_i, out_rx2_q}), 128'(0));
            check($sformatf("vec%0d_level", r), 128'(fifo_level), 128'(vecs[r].e_lvl));
            check($sformatf("vec%0d_udr", r), 128'(iq_underrun), 128'(vecs[r].e_udr));
        end

        // Paired frame: RX1 strobe, RX2 strobe five cycles later, one push one cycle after.
        rx2_en = 1;
        idle(1);
        strobe1(24'h111111, 24'h222222);
        idle(4);
        cyc(0, '0, '0, 1, 24'h7FFFFF, 24'h800000, 0, 0);
        check("pair_lvl_at_strobe", 128'(fifo_level), 128'(0));
        idle(1);
        check("pair_lvl_push", 128'(fifo_level), 128'(1));
        idle(2);
        check("pair_lvl_single", 128'(fifo_level), 128'(1));
        read1();
        check("pair_valid", 128'(out_valid), 128'(1));
        check("pair_frame", out_frame(), 128'(96'h111111_222222_7FFFFF_800000));
        check("pair_lvl_after", 128'(fifo_level), 128'(0));

        // Overrun on a 9th frame, clear, then full push with simultaneous pop.
        rx2_en = 0;
        idle(1);
        for (int k = 1; k <= 9; k++) strobe1(DW'(k), '0);
        idle(1);
        check("ovr_level", 128'(fifo_level), 128'(8));
        check("ovr_flag", 128'(iq_overrun), 128'(1));
        cyc(0, '0, '0, 0, '0, '0, 0, 1);
        check("ovr_clr", 128'(iq_overrun), 128'(0));
        strobe1(24'h00000A, '0);
        read1();
        check("full_pp_valid", 128'(out_valid), 128'(1));
        check("full_pp_i", 128'(out_rx1_i), 128'(1));
        check("full_pp_level", 128'(fifo_level), 128'(8));
        check("full_pp_ovr", 128'(iq_overrun), 128'(0));
        for (int k = 0; k < 8; k++) begin
            read1();
            check($sformatf("drain%0d_i", k), 128'(out_rx1_i), 128'((k < 7) ? k + 2 : 10));
            check($sformatf("drain%0d_lvl", k), 128'(fifo_level), 128'(7 - k));
        end

        // rx2_en toggle flushes a partly filled queue.
        for (int k = 0; k < 5; k++) strobe1(DW'(8'h21 + k), '0);
        idle(1);
        check("flush_pre_level", 128'(fifo_level), 128'(5));
        rx2_en = 1;
        idle(1);
        check("flush_level", 128'(fifo_level), 128'(0));
        rx2_en = 0;
        idle(1);

        // Asynchronous reset while a pop is being presented.
        for (int k = 0; k < 4; k++) strobe1(DW'(8'h41 + k), 24'h000005);
        idle(1);
        check("rstmid_pre_level", 128'(fifo_level), 128'(4));
        read1();
        check("rstmid_pre_valid", 128'(out_valid), 128'(1));
        #1 reset_n = 0;
        #1;
        check("rstmid_valid", 128'(out_valid), 128'(0));
        check("rstmid_level", 128'(fifo_level), 128'(0));
        check("rstmid_frame", out_frame(), 128'(0));
        check("rstmid_flags", 128'({iq_overrun, iq_underrun}), 128'(0));
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);
        reset_n = 1;
        strobe1(24'h000099, 24'h000077);
        idle(1);
        check("resume_level", 128'(fifo_level), 128'(1));
        read1();
        check("resume_valid", 128'(out_valid), 128'(1));
        check("resume_frame", out_frame(), 128'(96'h000099_000077_000000_000000));

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rd_pct = ((n / 500) % 2 == 1) ? 20 : 60;
            if ($urandom_range(0, 199) == 0) rx2_en = ~rx2_en;
            if (rx1_en) begin
                if ($urandom_range(0, 299) == 0) rx1_en = 0;
            end else if ($urandom_range(0, 19) == 0) begin
                rx1_en = 1;
            end
            cyc(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom),
                1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom),
                ($urandom_range(0, 99) < rd_pct), ($urandom_range(0, 19) == 0));
            check("rnd_valid", 128'(out_valid), 128'(m_ov));
            check("rnd_frame", out_frame(), 128'(m_out));
            check("rnd_level", 128'(fifo_level), 128'(mq.size()));
            check("rnd_ovr", 128'(iq_overrun), 128'(m_ovr));
            check("rnd_udr", 128'(iq_underrun), 128'(m_udr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
